// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_resp_state_e;

  localparam logic [15:0] DMEM_LFSR_SEED         = 16'hACE1;
  localparam logic [31:0] DMEM_BASE_ADDR_DEFAULT = 32'h8000_0000;

  // One step of the 16-bit Galois LFSR (taps 16,14,13,11).
  function automatic logic [15:0] dmem_lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

endpackage

// File: rtl/dmem_resp_ram.sv
// Single-port synchronous RAM, 32-bit words, per-byte write enables,
// one-cycle read latency, read-during-write returns the old word.
module dmem_resp_ram #(
  parameter int unsigned DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [3:0]            we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem_q [0:(1<<DEPTH_LOG2)-1];

  // Enabled access: commit strobed lanes and register the pre-write word.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem_q[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the core data-memory interface, backed by dmem_resp_ram.
// Optional feature macro: DMEM_RESPONDER_RAND_WAIT_EN adds 0..3 random wait
// cycles per request from a free-running LFSR.
//
// Handshake: the initiator raises dmem_valid and holds addr/write/wdata/wstrb
// stable until it sees dmem_ready; a transfer completes on the rising edge where
// valid & ready are both high. Dropping valid before that edge abandons the
// request (no write, no ready pulse). ready is never high two cycles in a row.
module dmem_responder import mem_pkg::*; #(
  parameter int unsigned DEPTH_LOG2  = 12,
  parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR_DEFAULT,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dmem_valid,
  output logic             dmem_ready,
  input  logic [31:0]      dmem_addr,
  input  logic             dmem_write,
  input  logic [31:0]      dmem_wdata,
  input  logic [3:0]       dmem_wstrb,
  output logic [31:0]      dmem_rdata,
  output logic             dmem_err,
  output dmem_resp_state_e dbg_state
);

  localparam logic [4:0]  WAIT_INIT = 5'(WAIT_CYCLES);
  localparam logic [32:0] WIN_BYTES = 33'd4 << DEPTH_LOG2;

  dmem_resp_state_e state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [4:0]       cnt_load;
  logic [31:0]      offset;
  logic             in_range;
  logic             ram_en;
  logic [3:0]       ram_we;
  logic [31:0]      ram_rdata;

  // Window check: the unsigned subtract makes both BASE-4 and BASE+size wrap out.
  assign offset   = dmem_addr - BASE_ADDR;
  assign in_range = ({1'b0, offset} < WIN_BYTES);

`ifdef DMEM_RESPONDER_RAND_WAIT_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d   = dmem_lfsr_next(lfsr_q);
  assign cnt_load = WAIT_INIT + {3'b000, lfsr_q[1:0]};

  // Free-running LFSR supplying the random extra wait count.
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= DMEM_LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end
`else
  assign cnt_load = WAIT_INIT;
`endif

  // State and wait-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, counter and RAM control; the RAM read fires on the edge into RESP
  // and the write fires on the handshake edge out of RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ram_en  = 1'b0;
    ram_we  = 4'b0000;
    case (state_q)
      IDLE: begin
        if (dmem_valid) begin
          cnt_d = cnt_load;
          if (cnt_load != 5'd0) begin
            state_d = WAIT;
          end else begin
            state_d = RESP;
            ram_en  = 1'b1;
          end
        end
      end
      WAIT: begin
        if (!dmem_valid) begin
          state_d = IDLE;
          cnt_d   = 5'd0;
        end else begin
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            state_d = RESP;
            ram_en  = 1'b1;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = 5'd0;
        if (dmem_valid && dmem_write && in_range && !rst) begin
          ram_en = 1'b1;
          ram_we = dmem_wstrb;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 5'd0;
      end
    endcase
  end

  // Response outputs are only non-zero while a live request sits in RESP.
  always_comb begin
    dmem_ready = (state_q == RESP) && dmem_valid;
    dmem_err   = dmem_ready && !in_range;
    dmem_rdata = (dmem_ready && in_range) ? ram_rdata : 32'h0;
  end

  assign dbg_state = state_q;

  dmem_resp_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (offset[DEPTH_LOG2+1:2]),
    .wdata(dmem_wdata),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (BASE 0x8000_0000, 16 words, 2 wait cycles).
module tb_dmem_responder;
  import mem_pkg::*;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic             clk;
  logic             rst;
  logic             dmem_valid;
  logic             dmem_ready;
  logic [31:0]      dmem_addr;
  logic             dmem_write;
  logic [31:0]      dmem_wdata;
  logic [3:0]       dmem_wstrb;
  logic [31:0]      dmem_rdata;
  logic             dmem_err;
  dmem_resp_state_e dbg_state;

  int n_chk;
  int n_fail;
  logic [31:0] mem_m [16];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        chk_rd;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [16];

  dmem_responder #(
    .DEPTH_LOG2 (4),
    .BASE_ADDR  (BASE),
    .WAIT_CYCLES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .dmem_valid(dmem_valid),
    .dmem_ready(dmem_ready),
    .dmem_addr (dmem_addr),
    .dmem_write(dmem_write),
    .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb),
    .dmem_rdata(dmem_rdata),
    .dmem_err  (dmem_err),
    .dbg_state (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_lat(input string name, input int lat);
    logic ok;
    n_chk++;
`ifdef DMEM_RESPONDER_RAND_WAIT_EN
    ok = (lat >= 3) && (lat <= 6);
`else
    ok = (lat == 3);
`endif
    if (!ok) begin
      n_fail++;
      $display("FAIL %s latency: got %0d expected 3 (3..6 with random waits)", name, lat);
    end
  endtask

  function automatic logic [31:0] fill_word(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {8'h10 + b, 8'h20 + b, 8'h30 + b, 8'h40 + b};
  endfunction

  function automatic vec_t mk(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] st, input logic chk, input logic [31:0] erd,
                              input logic eerr);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = wd; v.wstrb = st;
    v.chk_rd = chk; v.exp_rdata = erd; v.exp_err = eerr;
    return v;
  endfunction

  // Reference memory update: strobed lanes land only for in-window addresses.
  task automatic model_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st);
    logic [31:0] off;
    off = a - BASE;
    if (off < 32'd64) begin
      for (int i = 0; i < 4; i++)
        if (st[i]) mem_m[off[5:2]][8*i +: 8] = wd[8*i +: 8];
    end
  endtask

  // Driver: presents one request at a negedge, waits for ready (bounded),
  // samples the response, completes the handshake and releases valid.
  task automatic do_req(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] st, output logic [31:0] rd, output logic er,
                        output int lat);
    dmem_valid = 1'b1; dmem_write = wr; dmem_addr = a; dmem_wdata = wd; dmem_wstrb = st;
    lat = 0; rd = 32'h0; er = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (dmem_ready) begin
        lat = i;
        break;
      end
    end
    rd = dmem_rdata;
    er = dmem_err;
    @(negedge clk);
    dmem_valid = 1'b0; dmem_write = 1'b0; dmem_addr = 32'h0; dmem_wdata = 32'h0; dmem_wstrb = 4'h0;
  endtask

  // Waits for ready while holding the current request; returns the cycle count (0 = timeout).
  task automatic wait_ready(output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (dmem_ready) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    n_chk = 0; n_fail = 0;
    rst = 1'b1; dmem_valid = 1'b0; dmem_write = 1'b0;
    dmem_addr = 32'h0; dmem_wdata = 32'h0; dmem_wstrb = 4'h0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset ready", {31'b0, dmem_ready}, 32'h0);
    check("reset err",   {31'b0, dmem_err},   32'h0);
    check("reset rdata", dmem_rdata,          32'h0);
    check("reset state", {30'b0, dbg_state},  {30'b0, IDLE});
    rst = 1'b0;
    @(negedge clk);

    // Known contents for every word
    for (int i = 0; i < 16; i++) begin
      mem_m[i] = fill_word(i);
      do_req(1'b1, BASE + 32'(4*i), fill_word(i), 4'hF, rd, er, lat);
      check("fill err", {31'b0, er}, 32'h0);
      check_lat("fill", lat);
    end

    // Directed vectors with hand-computed results
    vecs[0]  = mk(1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0,         1'b0);
    vecs[1]  = mk(1'b0, 32'h8000_0004, 32'h0,         4'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    vecs[2]  = mk(1'b1, 32'h8000_0006, 32'h00AB_0000, 4'h4, 1'b0, 32'h0,         1'b0);
    vecs[3]  = mk(1'b0, 32'h8000_0004, 32'h0,         4'h0, 1'b1, 32'hDEAB_BEEF, 1'b0);
    vecs[4]  = mk(1'b0, 32'h8000_0005, 32'h0,         4'h0, 1'b1, 32'hDEAB_BEEF, 1'b0);
    vecs[5]  = mk(1'b0, 32'h8000_0040, 32'h0,         4'h0, 1'b1, 32'h0,         1'b1);
    vecs[6]  = mk(1'b1, 32'h7FFF_FFFC, 32'h0000_0001, 4'hF, 1'b0, 32'h0,         1'b1);
    vecs[7]  = mk(1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0, 1'b1, 32'h0,         1'b1);
    vecs[8]  = mk(1'b1, 32'h8000_0008, 32'hA5A5_A5A5, 4'hF, 1'b0, 32'h0,         1'b0);
    vecs[9]  = mk(1'b1, 32'h8000_0008, 32'hFF00_00EE, 4'h9, 1'b0, 32'h0,         1'b0);
    vecs[10] = mk(1'b0, 32'h8000_0008, 32'h0,         4'h0, 1'b1, 32'hFFA5_A5EE, 1'b0);
    vecs[11] = mk(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 4'h0, 1'b0, 32'h0,         1'b0);
    vecs[12] = mk(1'b0, 32'h8000_0000, 32'h0,         4'h0, 1'b1, 32'h1020_3040, 1'b0);
    vecs[13] = mk(1'b1, 32'h8000_003C, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0,         1'b0);
    vecs[14] = mk(1'b0, 32'h8000_003C, 32'h0,         4'h0, 1'b1, 32'hCAFE_F00D, 1'b0);
    vecs[15] = mk(1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 1'b1, 32'h0,         1'b1);

    for (int v = 0; v < 16; v++) begin
      do_req(vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].wstrb, rd, er, lat);
      if (vecs[v].wr) model_write(vecs[v].addr, vecs[v].wdata, vecs[v].wstrb);
      check($sformatf("vec%0d err", v), {31'b0, er}, {31'b0, vecs[v].exp_err});
      check_lat($sformatf("vec%0d", v), lat);
      if (vecs[v].chk_rd) check($sformatf("vec%0d rdata", v), rd, vecs[v].exp_rdata);
    end

    // Flush in WAIT: write abandoned after one cycle
    dmem_valid = 1'b1; dmem_write = 1'b1; dmem_addr = 32'h8000_0008;
    dmem_wdata = 32'h1234_5678; dmem_wstrb = 4'hF;
    @(negedge clk);
    check("flush wait state", {30'b0, dbg_state}, {30'b0, WAIT});
    check("flush wait ready", {31'b0, dmem_ready}, 32'h0);
    dmem_valid = 1'b0; dmem_write = 1'b0;
    @(negedge clk);
    check("flush idle state", {30'b0, dbg_state}, {30'b0, IDLE});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("flush no ready", {31'b0, dmem_ready}, 32'h0);
    end
    do_req(1'b0, 32'h8000_0008, 32'h0, 4'h0, rd, er, lat);
    check("flush readback", rd, 32'hFFA5_A5EE);
    check_lat("after flush", lat);

    // Flush in RESP: valid drops while ready is showing
    dmem_valid = 1'b1; dmem_write = 1'b1; dmem_addr = 32'h8000_0010;
    dmem_wdata = 32'h0000_0000; dmem_wstrb = 4'hF;
    wait_ready(lat);
    check_lat("resp flush", lat);
    dmem_valid = 1'b0; dmem_write = 1'b0;
    #1;
    check("resp flush ready", {31'b0, dmem_ready}, 32'h0);
    @(negedge clk);
    check("resp flush state", {30'b0, dbg_state}, {30'b0, IDLE});
    do_req(1'b0, 32'h8000_0010, 32'h0, 4'h0, rd, er, lat);
    check("resp flush readback", rd, 32'h1424_3444);

    // Reset during RESP discards the pending write
    dmem_valid = 1'b1; dmem_write = 1'b1; dmem_addr = 32'h8000_000C;
    dmem_wdata = 32'hFFFF_FFFF; dmem_wstrb = 4'hF;
    wait_ready(lat);
    check_lat("rst in resp", lat);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; dmem_valid = 1'b0; dmem_write = 1'b0;
    check("rst resp ready", {31'b0, dmem_ready}, 32'h0);
    check("rst resp state", {30'b0, dbg_state}, {30'b0, IDLE});
    do_req(1'b0, 32'h8000_000C, 32'h0, 4'h0, rd, er, lat);
    check("rst resp readback", rd, 32'h1323_3343);

`ifdef DMEM_RESPONDER_RAND_WAIT_EN
    // Random traffic against the reference memory
    begin
      logic [3:0]  seen;
      logic [31:0] a, wd, exp_rd;
      logic [3:0]  st;
      logic        wr, inr;
      seen = 4'h0;
      for (int n = 0; n < 200; n++) begin
        a   = BASE + 32'(4 * $urandom_range(0, 17)) + 32'($urandom_range(0, 3));
        if ($urandom_range(0, 9) == 0) a = BASE - 32'd4;
        wr  = 1'($urandom_range(0, 1));
        wd  = $urandom;
        st  = 4'($urandom_range(0, 15));
        inr = (a - BASE) < 32'd64;
        exp_rd = inr ? mem_m[4'((a - BASE) >> 2)] : 32'h0;
        do_req(wr, a, wd, st, rd, er, lat);
        if (wr) model_write(a, wd, st);
        else    check("rand rdata", rd, exp_rd);
        check("rand err", {31'b0, er}, {31'b0, ~inr});
        check_lat("rand", lat);
        if (lat >= 3 && lat <= 6) seen[lat-3] = 1'b1;
      end
      check("rand extra-wait coverage", {28'b0, seen}, 32'h0000_000F);
    end
`endif

    // Whole-array sweep against the reference memory
    for (int i = 0; i < 16; i++) begin
      do_req(1'b0, BASE + 32'(4*i), 32'h0, 4'h0, rd, er, lat);
      check($sformatf("sweep word%0d", i), rd, mem_m[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
